noc_credit_axis_bridge: RTL and testbench

// - Router local-output sink: consumes router port 0 (data/dest/is_tail/send, credit-based) and presents AXI-Stream master.
// - Single-clock (clk_noc) replacement for deserializer shim when SERIALIZATION_FACTOR=CLKCROSS_FACTOR=1.
// - Buffers flits in a FLIT_BUFFER_DEPTH FIFO and returns one credit per flit popped; tracks packets, flags protocol errors.

---
 rtl/noc_pkg.sv | 17 +
 rtl/noc_flit_fifo.sv | 57 +++++
 rtl/noc_credit_axis_bridge.sv | 115 +++++++++++
 tb/tb_noc_credit_axis_bridge.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit types and widths for the NoC-to-AXIS bridge
package noc_pkg;

  localparam int TDATA_WIDTH = 128;
  localparam int TID_WIDTH   = 2;
  localparam int TDEST_WIDTH = 2;
  localparam int DEST_WIDTH  = TID_WIDTH + TDEST_WIDTH;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0]  dest;
    logic                   tail;
  } flit_t;

  typedef enum logic {PKT_IDLE, PKT_BODY} pkt_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - show-ahead flit FIFO with occupancy count
module noc_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses pushes even when a pop happens the same cycle.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_credit_axis_bridge.sv
// rtl/noc_credit_axis_bridge.sv - credit-based router sink presenting an AXI-Stream master
module noc_credit_axis_bridge
  import noc_pkg::*;
#(
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int PKT_CNT_WIDTH     = 16
) (
  input  logic                     clk_noc,
  input  logic                     rst,
  input  logic [TDATA_WIDTH-1:0]   data_in,
  input  logic [DEST_WIDTH-1:0]    dest_in,
  input  logic                     is_tail_in,
  input  logic                     send_in,
  output logic                     credit_out,
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
  output logic                     axis_out_tlast,
  output logic [TID_WIDTH-1:0]     axis_out_tid,
  output logic [TDEST_WIDTH-1:0]   axis_out_tdest,
  output logic                     overflow_err,
  output logic                     proto_err,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

  localparam int CW = $clog2(FLIT_BUFFER_DEPTH) + 1;
  localparam logic [PKT_CNT_WIDTH-1:0] PKT_ONE = PKT_CNT_WIDTH'(1);

  flit_t             wr_flit;
  flit_t             head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  pkt_state_e        state;
  pkt_state_e        state_next;
  logic [DEST_WIDTH-1:0] dest_latched;
  logic              latch_dest;
  logic              dest_mismatch;

  assign wr_flit = '{data: data_in, dest: dest_in, tail: is_tail_in};
  assign push    = send_in & ~full;
  assign pop     = ~empty & axis_out_tready;

  noc_flit_fifo #(
    .DEPTH (FLIT_BUFFER_DEPTH),
    .WIDTH ($bits(flit_t))
  ) u_fifo (
    .clk   (clk_noc),
    .rst   (rst),
    .push  (push),
    .wdata (wr_flit),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign axis_out_tvalid = ~empty;
  assign axis_out_tdata  = head.data;
  assign axis_out_tlast  = head.tail;
  assign axis_out_tid    = head.dest[DEST_WIDTH-1 -: TID_WIDTH];
  assign axis_out_tdest  = head.dest[TDEST_WIDTH-1:0];

  // Packet tracking state register; only accepted flits advance it.
  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      state        <= PKT_IDLE;
      dest_latched <= '0;
    end else begin
      state <= state_next;
      if (latch_dest) dest_latched <= dest_in;
    end
  end

  // Packet next-state: head flit latches dest, body flits are compared against it.
  always_comb begin
    state_next    = state;
    latch_dest    = 1'b0;
    dest_mismatch = 1'b0;
    case (state)
      PKT_IDLE: begin
        if (push && !is_tail_in) begin
          state_next = PKT_BODY;
          latch_dest = 1'b1;
        end
      end
      PKT_BODY: begin
        if (push) begin
          dest_mismatch = (dest_in != dest_latched);
          if (is_tail_in) state_next = PKT_IDLE;
        end
      end
      default: state_next = PKT_IDLE;
    endcase
  end

  // Credit return, sticky error flags and delivered-packet counter.
  always_ff @(posedge clk_noc or posedge rst) begin
    if (rst) begin
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
      pkt_count    <= '0;
    end else begin
      credit_out <= pop;
      if (send_in && full) overflow_err <= 1'b1;
      if (dest_mismatch)   proto_err    <= 1'b1;
      if (pop && head.tail) pkt_count   <= pkt_count + PKT_ONE;
    end
  end

endmodule

// File: tb/tb_noc_credit_axis_bridge.sv
// tb/tb_noc_credit_axis_bridge.sv - directed self-checking bench for noc_credit_axis_bridge
module tb_noc_credit_axis_bridge;

  logic         clk_noc = 1'b0;
  logic         rst;
  logic [127:0] data_in;
  logic [3:0]   dest_in;
  logic         is_tail_in;
  logic         send_in;
  logic         credit_out;
  logic         axis_out_tvalid;
  logic         axis_out_tready;
  logic [127:0] axis_out_tdata;
  logic         axis_out_tlast;
  logic [1:0]   axis_out_tid;
  logic [1:0]   axis_out_tdest;
  logic         overflow_err;
  logic         proto_err;
  logic [15:0]  pkt_count;

  int checks   = 0;
  int failures = 0;
  int credits;

  noc_credit_axis_bridge #(
    .FLIT_BUFFER_DEPTH (4),
    .PKT_CNT_WIDTH     (16)
  ) dut (
    .clk_noc         (clk_noc),
    .rst             (rst),
    .data_in         (data_in),
    .dest_in         (dest_in),
    .is_tail_in      (is_tail_in),
    .send_in         (send_in),
    .credit_out      (credit_out),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tid    (axis_out_tid),
    .axis_out_tdest  (axis_out_tdest),
    .overflow_err    (overflow_err),
    .proto_err       (proto_err),
    .pkt_count       (pkt_count)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic set_flit(input logic [127:0] d, input logic [3:0] dst, input logic tl);
    send_in    = 1'b1;
    data_in    = d;
    dest_in    = dst;
    is_tail_in = tl;
  endtask

  initial begin
    rst             = 1'b1;
    send_in         = 1'b0;
    data_in         = '0;
    dest_in         = '0;
    is_tail_in      = 1'b0;
    axis_out_tready = 1'b0;
    tick();
    tick();
    check("rst_tvalid", axis_out_tvalid, 0);
    check("rst_credit", credit_out, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_proto", proto_err, 0);
    rst = 1'b0;
    tick();

    // Single flit, tready high
    axis_out_tready = 1'b1;
    set_flit({16{8'hA5}}, 4'b0110, 1'b1);
    tick();
    send_in = 1'b0;
    check("single_tvalid", axis_out_tvalid, 1);
    check("single_tdata", axis_out_tdata, {16{8'hA5}});
    check("single_tid", axis_out_tid, 2'b01);
    check("single_tdest", axis_out_tdest, 2'b10);
    check("single_tlast", axis_out_tlast, 1);
    check("single_credit_early", credit_out, 0);
    tick();
    check("single_credit", credit_out, 1);
    check("single_pkt_count", pkt_count, 1);
    check("single_drained", axis_out_tvalid, 0);
    tick();
    check("single_credit_one_pulse", credit_out, 0);

    // Four-flit packet with tready low fills the FIFO
    axis_out_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_flit(128'h10 + 128'(i), 4'h1, (i == 3));
      tick();
      check("fill_no_credit", credit_out, 0);
    end
    check("fill_tvalid", axis_out_tvalid, 1);
    check("fill_head", axis_out_tdata, 128'h10);

    // Fifth flit while full is dropped
    set_flit(128'hFF, 4'h1, 1'b1);
    tick();
    send_in = 1'b0;
    check("full_overflow", overflow_err, 1);
    check("full_head_kept", axis_out_tdata, 128'h10);
    tick();
    check("overflow_sticky", overflow_err, 1);

    // Drain: one pop and one credit per cycle, tlast only on the last flit
    axis_out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_tdata", axis_out_tdata, 128'h10 + 128'(i));
      check("drain_tlast", axis_out_tlast, (i == 3));
      tick();
      check("drain_credit", credit_out, 1);
    end
    check("drain_empty", axis_out_tvalid, 0);
    check("drain_pkt_count", pkt_count, 2);
    tick();
    check("drain_credit_end", credit_out, 0);

    // Streaming push and pop every cycle, tail on every third flit
    credits = 0;
    for (int i = 0; i < 100; i++) begin
      set_flit(128'h1000 + 128'(i), 4'h2, (i % 3 == 0));
      tick();
      check("stream_tvalid", axis_out_tvalid, 1);
      check("stream_tdata", axis_out_tdata, 128'h1000 + 128'(i));
      check("stream_tlast", axis_out_tlast, (i % 3 == 0));
      if (credit_out) credits++;
    end
    send_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (credit_out) credits++;
    end
    check("stream_credits", credits, 100);
    check("stream_pkt_count", pkt_count, 36);
    check("stream_empty", axis_out_tvalid, 0);
    check("stream_no_proto", proto_err, 0);

    // Destination change mid-packet flags proto_err but still delivers in order
    set_flit(128'h100, 4'h3, 1'b0);
    tick();
    check("proto_head0", axis_out_tdata, 128'h100);
    check("proto_clear_yet", proto_err, 0);
    set_flit(128'h101, 4'h5, 1'b1);
    tick();
    send_in = 1'b0;
    check("proto_err", proto_err, 1);
    check("proto_head1", axis_out_tdata, 128'h101);
    check("proto_tdest", axis_out_tdest, 2'b01);
    tick();
    check("proto_pkt_count", pkt_count, 37);
    check("proto_sticky", proto_err, 1);

    // Reset with three flits queued clears everything immediately
    axis_out_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_flit(128'h200 + 128'(i), 4'h0, (i == 2));
      tick();
    end
    send_in = 1'b0;
    check("prerst_tvalid", axis_out_tvalid, 1);
    rst = 1'b1;
    #1;
    check("arst_tvalid", axis_out_tvalid, 0);
    check("arst_credit", credit_out, 0);
    check("arst_pkt_count", pkt_count, 0);
    check("arst_overflow", overflow_err, 0);
    check("arst_proto", proto_err, 0);
    @(negedge clk_noc);
    rst = 1'b0;
    axis_out_tready = 1'b1;
    tick();
    check("postrst_tvalid", axis_out_tvalid, 0);
    check("postrst_credit", credit_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
